// File: rtl/constraint_eval_seq.sv
// Sequential constraint-conjunction evaluator: one programmable term per cycle, early exit on first false term.
// Optional run/sat counters are built when CONSTRAINT_EVAL_STATS_EN is defined.
module constraint_eval_seq #(
  parameter  int NUM_VARS  = 8,
  parameter  int VAR_W     = 16,
  parameter  int NUM_TERMS = 16,
  localparam int IDX_W     = $clog2(NUM_VARS),
  localparam int TIDX_W    = $clog2(NUM_TERMS),
  localparam int CFG_W     = 4 + 2*IDX_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [TIDX_W-1:0]         cfg_idx,
  input  logic [CFG_W-1:0]          cfg_data,
  output logic                      cfg_ack,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_VARS*VAR_W-1:0] in_vars,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sat,
  output logic [TIDX_W-1:0]         out_fail_idx,
  output logic                      busy
`ifdef CONSTRAINT_EVAL_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [31:0]               stat_runs,
  output logic [31:0]               stat_sat
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t r_state, w_next;

  logic [NUM_TERMS-1:0][CFG_W-1:0]  r_tbl;
  logic [NUM_VARS-1:0][VAR_W-1:0]   r_vars;
  logic [TIDX_W-1:0]                r_ptr;
  logic                             r_sat;
  logic [TIDX_W-1:0]                r_fidx;
  logic                             r_ack;

  logic [CFG_W-1:0] w_term;
  logic             w_en;
  logic [2:0]       w_op;
  logic [IDX_W-1:0] w_aidx, w_bidx;
  logic [VAR_W-1:0] w_a, w_b, w_res;
  logic             w_true, w_last, w_acc, w_cfg_ok, w_hs;

  assign w_term = r_tbl[r_ptr];
  assign w_en   = w_term[CFG_W-1];
  assign w_op   = w_term[CFG_W-2 -: 3];
  assign w_aidx = w_term[2*IDX_W-1 -: IDX_W];
  assign w_bidx = w_term[IDX_W-1:0];

  // Indices with no matching variable fall through to zero.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (w_aidx == IDX_W'(i)) w_a = r_vars[i];
      if (w_bidx == IDX_W'(i)) w_b = r_vars[i];
    end
  end

  always_comb begin
    w_res = '0;
    case (w_op)
      3'd0: w_res = w_a ^ w_b;
      3'd1: w_res = w_a & w_b;
      3'd2: w_res = w_a | w_b;
      3'd3: w_res = w_a + w_b;
      3'd4: w_res = w_a - w_b;
      3'd5: w_res = {{(VAR_W-1){1'b0}}, (w_a != w_b)};
      3'd6: w_res = {{(VAR_W-1){1'b0}}, ((|w_a) || (|w_b))};
      3'd7: w_res = {{(VAR_W-1){1'b0}}, ((|w_a) && (|w_b))};
      default: w_res = '0;
    endcase
  end

  assign w_true   = !w_en || (|w_res);
  assign w_last   = (r_ptr == TIDX_W'(NUM_TERMS-1));
  assign w_acc    = in_valid && (r_state == S_IDLE);
  assign w_cfg_ok = cfg_we && (r_state == S_IDLE);
  assign w_hs     = (r_state == S_DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_next = S_EVAL;
      S_EVAL: if (!w_true || w_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tbl  <= '0;
      r_vars <= '0;
      r_ptr  <= '0;
      r_sat  <= 1'b0;
      r_fidx <= '0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= w_cfg_ok;
      // Table write lands before the accepted run reads it on the following cycle.
      if (w_cfg_ok) r_tbl[cfg_idx] <= cfg_data;
      if (w_acc) begin
        r_vars <= in_vars;
        r_ptr  <= '0;
      end
      if (r_state == S_EVAL) begin
        if (!w_true) begin
          r_sat  <= 1'b0;
          r_fidx <= r_ptr;
        end else if (w_last) begin
          r_sat  <= 1'b1;
          r_fidx <= '0;
        end else begin
          r_ptr <= r_ptr + TIDX_W'(1);
        end
      end
    end
  end

  assign cfg_ack      = r_ack;
  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign out_sat      = r_sat;
  assign out_fail_idx = r_fidx;
  assign busy         = (r_state != S_IDLE);

`ifdef CONSTRAINT_EVAL_STATS_EN
  logic [31:0] r_runs, r_satc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_runs <= '0;
      r_satc <= '0;
    end else if (stat_clr) begin
      r_runs <= '0;
      r_satc <= '0;
    end else if (w_hs) begin
      if (r_runs != 32'hFFFF_FFFF) r_runs <= r_runs + 32'd1;
      if (r_sat && (r_satc != 32'hFFFF_FFFF)) r_satc <= r_satc + 32'd1;
    end
  end

  assign stat_runs = r_runs;
  assign stat_sat  = r_satc;
`endif

endmodule

// File: tb/tb_constraint_eval_seq.sv
// Scoreboard bench for constraint_eval_seq, built with NUM_VARS=6 so out-of-range operand indices are reachable.
module tb_constraint_eval_seq;
  localparam int NV = 6, VW = 16, NT = 16;
  localparam int TW = 4, CW = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0, cfg_ack;
  logic [TW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic [NV*VW-1:0] in_vars = '0;
  logic out_valid, out_ready = 1'b1, out_sat, busy;
  logic [TW-1:0] out_fail_idx;
`ifdef CONSTRAINT_EVAL_STATS_EN
  logic stat_clr = 1'b0;
  logic [31:0] stat_runs, stat_sat;
`endif

  constraint_eval_seq #(.NUM_VARS(NV), .VAR_W(VW), .NUM_TERMS(NT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .in_valid(in_valid), .in_ready(in_ready), .in_vars(in_vars),
    .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
    .out_fail_idx(out_fail_idx), .busy(busy)
`ifdef CONSTRAINT_EVAL_STATS_EN
    , .stat_clr(stat_clr), .stat_runs(stat_runs), .stat_sat(stat_sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic sat; logic [TW-1:0] idx; int lat; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_err = 0, n_sent = 0, n_resp = 0;
  int cyc = 0, acc_cyc = 0;
  logic prev_v = 1'b0, h_sat;
  logic [TW-1:0] h_idx;

  localparam logic [2:0] XOR = 3'd0, AND = 3'd1, OR = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, NEQ = 3'd5, LOR = 3'd6, LAND = 3'd7;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expectation on each new result, then checks hold-stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !prev_v) begin
        if (q.size() == 0) chk("unexpected_out_valid", 32'(q.size()), 32'd1);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("out_sat", 32'(out_sat), 32'(e.sat));
          chk("out_fail_idx", 32'(out_fail_idx), 32'(e.idx));
          chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          h_sat = out_sat;
          h_idx = out_fail_idx;
        end
      end else if (out_valid) begin
        chk("hold_sat", 32'(out_sat), 32'(h_sat));
        chk("hold_idx", 32'(out_fail_idx), 32'(h_idx));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) n_resp++;
      prev_v = out_valid;
    end
  end

  task automatic wr(input logic [3:0] slot, input logic en, input logic [2:0] op,
                    input logic [2:0] a, input logic [2:0] b, input logic exp_ack);
    cfg_we = 1'b1; cfg_idx = slot; cfg_data = {en, op, a, b};
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk); chk("cfg_ack", 32'(cfg_ack), 32'(exp_ack));
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [NV*VW-1:0] v, input logic s, input logic [3:0] k);
    exp_t e;
    logic ok;
    e.sat = s; e.idx = s ? 4'd0 : k; e.lat = s ? NT + 1 : int'(k) + 2;
    q.push_back(e);
    n_sent++;
    in_vars = v; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    chk("accept", 32'(ok), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_resp();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (n_resp >= n_sent) done = 1'b1;
    end
    chk("response", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_case(input logic [3:0] slot, input logic [2:0] op, input logic [2:0] a,
                          input logic [2:0] b, input logic [NV*VW-1:0] v,
                          input logic s, input logic [3:0] k);
    wr(slot, 1'b1, op, a, b, 1'b1);
    send(v, s, k);
    wait_resp();
    wr(slot, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1);
  endtask

  initial begin
    logic bad;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_fail_idx", 32'(out_fail_idx), 32'd0);
    chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Empty table: every term disabled, full-length satisfied run.
    send({16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1, 4'd0);
    @(negedge clk); chk("busy_in_eval", 32'(busy), 32'd1);
    @(posedge clk); #1;
    wait_resp();

    //        slot  op    a     b     {v5,v4,v3,v2,v1,v0}                                          sat  idx
    run_case(4'd0,  XOR,  3'd0, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h1234},             1'b0, 4'd0);
    run_case(4'd0,  XOR,  3'd0, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h1235, 16'h1234},             1'b1, 4'd0);
    run_case(4'd2,  SUB,  3'd3, 3'd3, {16'h0, 16'h0, 16'h5555, 16'h0, 16'h0, 16'h0},                1'b0, 4'd2);
    run_case(4'd5,  ADD,  3'd4, 3'd5, {16'h0001, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0},             1'b0, 4'd5);
    run_case(4'd5,  ADD,  3'd4, 3'd5, {16'h0002, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0},             1'b1, 4'd0);
    run_case(4'd1,  AND,  3'd7, 3'd0, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF},                1'b0, 4'd1);
    run_case(4'd3,  AND,  3'd0, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h000F, 16'h00F0},             1'b0, 4'd3);
    run_case(4'd15, OR,   3'd0, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},                   1'b0, 4'd15);
    run_case(4'd15, NEQ,  3'd2, 3'd3, {16'h0, 16'h0, 16'hABCD, 16'hABCD, 16'h0, 16'h0},             1'b0, 4'd15);
    run_case(4'd7,  LOR,  3'd6, 3'd7, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b0, 4'd7);
    run_case(4'd7,  LAND, 3'd0, 3'd6, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001},                1'b0, 4'd7);
    run_case(4'd7,  LAND, 3'd0, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0001},             1'b1, 4'd0);
    run_case(4'd9,  NEQ,  3'd0, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0001},             1'b1, 4'd0);

    // Backpressure with a dropped write while the result is held.
    wr(4'd4, 1'b1, SUB, 3'd0, 3'd1, 1'b1);
    out_ready = 1'b0;
    send({16'h0, 16'h0, 16'h0, 16'h0, 16'h7777, 16'h7777}, 1'b0, 4'd4);
    bad = 1'b1;
    for (int i = 0; i < 40 && bad; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b0;
    end
    chk("bp_out_valid", 32'(bad), 32'd0);
    @(posedge clk); #1;
    wr(4'd8, 1'b1, XOR, 3'd0, 3'd0, 1'b0);
    repeat (8) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_resp();
    wr(4'd4, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1);

    // Dropped write during EVAL; the following run must still see an all-disabled table.
    send({16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1, 4'd0);
    wr(4'd6, 1'b1, XOR, 3'd0, 3'd0, 1'b0);
    wait_resp();
    send({16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1, 4'd0);
    wait_resp();

    // Write and accept in the same IDLE cycle: the run uses the new entry.
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_data = {1'b1, XOR, 3'd2, 3'd2};
    send({16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b0, 4'd0);
    cfg_we = 1'b0;
    @(negedge clk); chk("same_cycle_ack", 32'(cfg_ack), 32'd1);
    @(posedge clk); #1;
    wait_resp();
    wr(4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1);

    // Reset while evaluating term 3: result discarded and table cleared.
    wr(4'd10, 1'b1, XOR, 3'd0, 3'd0, 1'b1);
    send({16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b0, 4'd10);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    n_sent = n_resp;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy) bad = 1'b1;
    end
    chk("reset_no_out_valid", 32'(bad), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
`ifdef CONSTRAINT_EVAL_STATS_EN
    @(negedge clk); chk("stat_runs_after_rst", stat_runs, 32'd0);
    @(posedge clk); #1;
`endif
    send({16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1, 4'd0);
    wait_resp();
`ifdef CONSTRAINT_EVAL_STATS_EN
    @(negedge clk);
    chk("stat_runs_one", stat_runs, 32'd1);
    chk("stat_sat_one", stat_sat, 32'd1);
    @(posedge clk); #1 stat_clr = 1'b1;
    @(posedge clk); #1 stat_clr = 1'b0;
    @(negedge clk); chk("stat_clr", stat_runs, 32'd0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
